// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//  - opcode constants
//  - sequencer state encoding
//  - instruction field bit positions
//  - illegal-opcode classifier
package alu_seq_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_LDL  = 6'd5;
  localparam logic [5:0] OP_LDH  = 6'd6;
  localparam logic [5:0] OP_MOV  = 6'd7;
  localparam logic [5:0] OP_CEQ  = 6'd8;
  localparam logic [5:0] OP_CGE  = 6'd13;
  localparam logic [5:0] OP_JMP  = 6'd14;
  localparam logic [5:0] OP_BR   = 6'd15;
  localparam logic [5:0] OP_HALT = 6'd63;

  // Instruction layout: op[31:26] rd[25:22] ra[21:18] hl[17] imm[15:0], rb = imm[15:12]
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RA_MSB  = 21;
  localparam int unsigned RA_LSB  = 18;
  localparam int unsigned HL_BIT  = 17;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned RB_MSB  = 15;
  localparam int unsigned RB_LSB  = 12;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  function automatic logic is_illegal(input logic [5:0] op);
    return (op > OP_BR) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 16x32 register file.
//  clock, reset_n     : clock, async active-low clear of all entries
//  we, waddr, wdata   : synchronous write port
//  raddr_a/rdata_a    : async read port A
//  raddr_b/rdata_b    : async read port B
//  r8                 : dedicated tap of R[8]
module alu_seq_regfile (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] r8
);

  logic [31:0] regs [16];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign r8      = regs[8];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/exec/writeback control for an external ALU.
//  clock, reset_n          : clock, async active-low reset
//  imem_req/addr/valid/rdata : instruction fetch handshake (word address = PC)
//  alu_instr/a/b/reg8/value/highlow/f1/f2 : ALU operand and flag outputs
//  alu_c/f3/addrch/naddr   : ALU results, sampled at the edge ending EXEC
//  halted                  : core stopped
//  illegal                 : sticky illegal-opcode flag (only with ALU_SEQ_ILLEGAL_TRAP_EN)
// Macro ALU_SEQ_ILLEGAL_TRAP_EN: ops 16-62 halt the core instead of acting as NOPs.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [5:0]      alu_instr,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [31:0]     alu_reg8,
  output logic [15:0]     alu_value,
  output logic            alu_highlow,
  output logic            alu_f1,
  output logic            alu_f2,
  input  logic [31:0]     alu_c,
  input  logic            alu_f3,
  input  logic            alu_addrch,
  input  logic [31:0]     alu_naddr,
  output logic            halted
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            f1, f2;
  logic            started;   // low during reset and the first cycle after release
  logic [31:0]     c_q, naddr_q;
  logic            f3_q, addrch_q;
  logic            in_ex;
  logic [31:0]     rd_a, rd_b;
  logic            rf_we;
  logic [5:0]      op;
  logic            unused_bits;

  assign op          = ir[OP_MSB:OP_LSB];
  assign unused_bits = ^{naddr_q[31:PC_W], ir[16]};

  alu_seq_regfile u_rf (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (ir[RD_MSB:RD_LSB]),
    .wdata   (c_q),
    .raddr_a (ir[RA_MSB:RA_LSB]),
    .raddr_b (ir[RB_MSB:RB_LSB]),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .r8      (alu_reg8)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      f1       <= 1'b0;
      f2       <= 1'b0;
      started  <= 1'b0;
      c_q      <= '0;
      naddr_q  <= '0;
      f3_q     <= 1'b0;
      addrch_q <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
      case (state)
        ST_FETCH: if (imem_req && imem_valid) ir <= imem_rdata;
        ST_EXEC: begin
          c_q      <= alu_c;
          f3_q     <= alu_f3;
          addrch_q <= alu_addrch;
          naddr_q  <= alu_naddr;
        end
        ST_WB: begin
          if (op >= OP_CEQ && op <= OP_CGE) begin
            f2 <= f1;
            f1 <= f3_q;
          end
          // NOPs (ops 16-62) ignore the ALU branch indication
          if (op <= OP_BR && addrch_q) pc <= naddr_q[PC_W-1:0];
          else                         pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                  illegal <= 1'b0;
    else if (state == ST_DECODE && is_illegal(op)) illegal <= 1'b1;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH:  if (imem_req && imem_valid) state_nx = ST_DECODE;
      ST_DECODE: begin
        state_nx = ST_EXEC;
        if (op == OP_HALT) state_nx = ST_HALT;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (is_illegal(op)) state_nx = ST_HALT;
`endif
      end
      ST_EXEC:   state_nx = ST_WB;
      ST_WB:     state_nx = ST_FETCH;
      default:   state_nx = ST_HALT;
    endcase
  end

  // Operands are driven straight from IR and the regfile during DECODE/EXEC; neither
  // changes in those states, so the ALU sees stable inputs through EXEC.
  always_comb begin
    in_ex       = (state == ST_DECODE) || (state == ST_EXEC);
    imem_req    = started && (state == ST_FETCH);
    imem_addr   = pc;
    halted      = (state == ST_HALT);
    rf_we       = (state == ST_WB) && (op <= OP_MOV);
    alu_instr   = in_ex ? op : (started ? 6'h3F : 6'h00);
    alu_a       = in_ex ? rd_a : '0;
    alu_b       = in_ex ? rd_b : '0;
    alu_value   = in_ex ? ir[IMM_MSB:IMM_LSB] : '0;
    alu_highlow = in_ex & ir[HL_BIT];
    alu_f1      = f1;
    alu_f2      = f2;
  end

endmodule
